// File: rtl/r_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : r_multicycle_ctrl
// Description : Multi-cycle control unit for the R-type CPU. Sequences
//               FETCH / DECODE / EXEC / WB for each instruction, decodes
//               op/funct into a registered ALU op, and drives the PC, IR and
//               register-file write strobes. Undefined instructions park the
//               unit in a sticky TRAP state that only rst leaves.
// Revision    : 1.0 - initial multi-cycle release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1        clock, all state on rising edge
//   rst         in   1        synchronous reset, active high
//   run         in   1        1 = keep executing, 0 = stop at next boundary
//   imem_ready  in   1        instruction word valid on the IR input
//   op          in   OP_W     opcode from IR, sampled in DECODE
//   funct       in   FUNCT_W  funct from IR, sampled in DECODE
//   pc_we       out  1        PC update strobe
//   ir_we       out  1        IR load strobe
//   rf_we       out  1        register-file write strobe
//   aluop       out  ALUOP_W  registered ALU operation
//   busy        out  1        high in FETCH, DECODE, EXEC and WB
//   illegal     out  1        sticky undefined-instruction flag
//   retired     out  CNT_W    number of completed WB cycles (wraps)
// ============================================================================
module r_multicycle_ctrl #(
    parameter int OP_W        = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUOP_W     = 3,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               imem_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               pc_we,
    output logic               ir_we,
    output logic               rf_we,
    output logic [ALUOP_W-1:0] aluop,
    output logic               busy,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd5;

    // EXEC lasts EXEC_CYCLES cycles: the counter is loaded with N-1 and the
    // state leaves EXEC in the cycle the counter reads zero.
    localparam logic [3:0] c_EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    logic [2:0]         r_state;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;
    logic [3:0]         r_exec_cnt;

    logic               w_dec_ok;
    logic [2:0]         w_dec_op;

    // Instruction decode: R-type only (op all zeros), funct looked up in
    // the fixed table below.
    always_comb begin
        w_dec_ok = 1'b1;
        w_dec_op = 3'd0;
        case (funct)
            FUNCT_W'(6'b100000): w_dec_op = 3'd0; // add
            FUNCT_W'(6'b100010): w_dec_op = 3'd1; // sub
            FUNCT_W'(6'b100100): w_dec_op = 3'd2; // and
            FUNCT_W'(6'b100101): w_dec_op = 3'd3; // or
            FUNCT_W'(6'b100110): w_dec_op = 3'd4; // xor
            FUNCT_W'(6'b100111): w_dec_op = 3'd5; // nor
            FUNCT_W'(6'b101011): w_dec_op = 3'd6; // sltu
            FUNCT_W'(6'b000100): w_dec_op = 3'd7; // sllv
            default:             w_dec_ok = 1'b0;
        endcase
        if (op != '0) begin
            w_dec_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_aluop    <= '0;
            r_illegal  <= 1'b0;
            r_retired  <= '0;
            r_exec_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (run) begin
                        r_state <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (imem_ready) begin
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (w_dec_ok) begin
                        r_aluop    <= ALUOP_W'(w_dec_op);
                        r_exec_cnt <= c_EXEC_LOAD;
                        r_state    <= c_EXEC;
                    end else begin
                        r_illegal  <= 1'b1;
                        r_state    <= c_TRAP;
                    end
                end
                c_EXEC: begin
                    if (r_exec_cnt != 4'd0) begin
                        r_exec_cnt <= r_exec_cnt - 4'd1;
                    end else begin
                        r_state    <= c_WB;
                    end
                end
                c_WB: begin
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= run ? c_FETCH : c_IDLE;
                end
                c_TRAP: begin
                    r_state <= c_TRAP;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from state and masked by rst so that an aborted
    // instruction never writes the PC, IR or register file in the reset cycle.
    assign pc_we   = (r_state == c_FETCH) && imem_ready && !rst;
    assign ir_we   = (r_state == c_FETCH) && imem_ready && !rst;
    assign rf_we   = (r_state == c_WB) && !rst;
    assign busy    = (r_state != c_IDLE) && (r_state != c_TRAP);
    assign aluop   = r_aluop;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_r_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_r_multicycle_ctrl
// Description : Directed testbench for r_multicycle_ctrl. Instance A runs
//               with EXEC_CYCLES=1, CNT_W=4; instance B with EXEC_CYCLES=3,
//               CNT_W=16. Inputs are shared; the idle instance is held in
//               reset and the observed outputs are muxed by r_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       r_rst_a, r_rst_b, r_run, r_ready, r_sel;
    logic [5:0] r_op, r_funct;

    logic       w_pc_a, w_ir_a, w_rf_a, w_busy_a, w_ill_a;
    logic [2:0] w_alu_a;
    logic [3:0] w_ret_a;
    logic       w_pc_b, w_ir_b, w_rf_b, w_busy_b, w_ill_b;
    logic [2:0] w_alu_b;
    logic [15:0] w_ret_b;

    logic [31:0] w_pc, w_ir, w_rf, w_busy, w_ill, w_alu, w_ret;

    int n_vec = 0;
    int n_err = 0;
    int r_cyc = 0;
    int r_last_wb = -1;

    always #5 clk = ~clk;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    r_multicycle_ctrl #(.EXEC_CYCLES(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(r_rst_a), .run(r_run), .imem_ready(r_ready),
        .op(r_op), .funct(r_funct), .pc_we(w_pc_a), .ir_we(w_ir_a),
        .rf_we(w_rf_a), .aluop(w_alu_a), .busy(w_busy_a),
        .illegal(w_ill_a), .retired(w_ret_a)
    );

    r_multicycle_ctrl #(.EXEC_CYCLES(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(r_rst_b), .run(r_run), .imem_ready(r_ready),
        .op(r_op), .funct(r_funct), .pc_we(w_pc_b), .ir_we(w_ir_b),
        .rf_we(w_rf_b), .aluop(w_alu_b), .busy(w_busy_b),
        .illegal(w_ill_b), .retired(w_ret_b)
    );

    assign w_pc   = 32'(r_sel ? w_pc_b   : w_pc_a);
    assign w_ir   = 32'(r_sel ? w_ir_b   : w_ir_a);
    assign w_rf   = 32'(r_sel ? w_rf_b   : w_rf_a);
    assign w_busy = 32'(r_sel ? w_busy_b : w_busy_a);
    assign w_ill  = 32'(r_sel ? w_ill_b  : w_ill_a);
    assign w_alu  = 32'(r_sel ? w_alu_b  : w_alu_a);
    assign w_ret  = r_sel ? 32'(w_ret_b) : 32'(w_ret_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to the middle of the next cycle; inputs are applied here and
    // outputs sampled #1 later, well away from the rising edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    // Run one legal instruction starting in its FETCH cycle with imem_ready=1.
    // Returns at the negedge of the cycle after WB.
    task automatic do_instr(input logic [5:0] f, input logic [2:0] ea,
                            input int n, input bit keep, input bit spc);
        r_op = 6'd0; r_funct = f; r_ready = 1'b1; r_run = 1'b1;
        #1;
        chk("fetch_pc_we", w_pc, 1);
        chk("fetch_ir_we", w_ir, 1);
        chk("fetch_rf_we", w_rf, 0);
        nxt(); #1;
        chk("dec_pc_we", w_pc, 0);
        chk("dec_rf_we", w_rf, 0);
        chk("dec_busy", w_busy, 1);
        for (int i = 0; i < n; i++) begin
            nxt();
            r_run = keep;
            #1;
            chk("exec_aluop", w_alu, 32'(ea));
            chk("exec_rf_we", w_rf, 0);
            chk("exec_pc_we", w_pc, 0);
        end
        nxt(); #1;
        chk("wb_rf_we", w_rf, 1);
        chk("wb_aluop", w_alu, 32'(ea));
        chk("wb_pc_we", w_pc, 0);
        if (spc) begin
            if (r_last_wb >= 0) chk("wb_spacing", 32'(r_cyc - r_last_wb), 32'(3 + n));
            r_last_wb = r_cyc;
        end
        nxt();
    endtask

    // Step from IDLE into FETCH.
    task automatic start();
        r_run = 1'b1;
        nxt();
    endtask

    task automatic reset_sel();
        if (r_sel) r_rst_b = 1'b1; else r_rst_a = 1'b1;
        nxt(); nxt();
        r_rst_a = 1'b1; r_rst_b = 1'b1;
        if (r_sel) r_rst_b = 1'b0; else r_rst_a = 1'b0;
        r_run = 1'b0;
        #1;
    endtask

    logic [5:0] c_functs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        c_functs[0] = 6'b100000; c_functs[1] = 6'b100010;
        c_functs[2] = 6'b100100; c_functs[3] = 6'b100101;
        c_functs[4] = 6'b100110; c_functs[5] = 6'b100111;
        c_functs[6] = 6'b101011; c_functs[7] = 6'b000100;

        r_rst_a = 1'b1; r_rst_b = 1'b1; r_sel = 1'b0;
        r_run = 1'b1; r_ready = 1'b1; r_op = 6'd0; r_funct = 6'b100010;
        nxt(); nxt(); nxt(); #1;
        // Reset state with run/ready active: must stay quiet
        chk("rst_pc_we", w_pc, 0);
        chk("rst_ir_we", w_ir, 0);
        chk("rst_rf_we", w_rf, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_aluop", w_alu, 0);
        chk("rst_illegal", w_ill, 0);
        chk("rst_retired", w_ret, 0);

        // Basic sub instruction, then FETCH re-entered with run held
        nxt();
        r_rst_a = 1'b0; r_run = 1'b1;
        #1;
        chk("idle_busy", w_busy, 0);
        nxt();
        do_instr(6'b100010, 3'd1, 1, 1'b1, 1'b0);
        #1;
        chk("refetch_pc_we", w_pc, 1);
        chk("refetch_busy", w_busy, 1);
        chk("t1_retired", w_ret, 1);
        do_instr(6'b100000, 3'd0, 1, 1'b0, 1'b0);
        #1;
        chk("t1_idle_busy", w_busy, 0);
        chk("t1_retired2", w_ret, 2);

        // Illegal funct after a legal xor: TRAP, aluop holds, no strobes
        start();
        do_instr(6'b100110, 3'd4, 1, 1'b1, 1'b0);
        r_funct = 6'b101010;
        #1;
        chk("ill_fetch_pc_we", w_pc, 1);
        nxt(); nxt();
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("trap_busy", w_busy, 0);
            chk("trap_illegal", w_ill, 1);
            chk("trap_rf_we", w_rf, 0);
            chk("trap_pc_we", w_pc, 0);
            chk("trap_aluop", w_alu, 4);
            chk("trap_retired", w_ret, 3);
            nxt();
        end
        reset_sel();
        chk("trap_rst_illegal", w_ill, 0);
        chk("trap_rst_busy", w_busy, 0);

        // Illegal opcode with a valid funct
        start();
        r_op = 6'b000010; r_funct = 6'b100000;
        nxt(); nxt(); #1;
        chk("illop_illegal", w_ill, 1);
        chk("illop_busy", w_busy, 0);
        chk("illop_rf_we", w_rf, 0);
        reset_sel();

        // imem stall in FETCH for 5 cycles
        r_ready = 1'b0;
        start();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_pc_we", w_pc, 0);
            chk("stall_ir_we", w_ir, 0);
            chk("stall_busy", w_busy, 1);
            nxt();
        end
        do_instr(6'b100101, 3'd3, 1, 1'b0, 1'b0);
        #1;
        chk("stall_idle_busy", w_busy, 0);
        chk("stall_retired", w_ret, 1);

        // 17 instructions on a 4-bit counter; run dropped in the last EXEC
        reset_sel();
        start();
        for (int i = 0; i < 17; i++) begin
            do_instr(c_functs[i % 8], 3'(i % 8), 1, (i != 16), 1'b0);
            #1;
            chk("wrap_retired", w_ret, 32'((i + 1) % 16));
        end
        chk("wrap_idle_busy", w_busy, 0);
        nxt(); #1;
        chk("wrap_idle_pc_we", w_pc, 0);
        chk("wrap_idle_rf_we", w_rf, 0);

        // Instance B: sweep all functs, EXEC_CYCLES=3, 6-cycle WB spacing
        r_rst_a = 1'b1; r_sel = 1'b1;
        reset_sel();
        start();
        r_last_wb = -1;
        for (int i = 0; i < 8; i++) begin
            do_instr(c_functs[i], 3'(i), 3, (i != 7), 1'b1);
        end
        #1;
        chk("sweep_retired", w_ret, 8);
        chk("sweep_idle_busy", w_busy, 0);

        // rst during EXEC aborts the instruction
        start();
        do_instr(6'b100111, 3'd5, 3, 1'b1, 1'b0);
        r_funct = 6'b100010;
        nxt(); nxt();
        r_rst_b = 1'b1;
        #1;
        chk("abort_exec_rf_we", w_rf, 0);
        nxt();
        r_rst_b = 1'b0; r_run = 1'b0;
        #1;
        chk("abort_exec_busy", w_busy, 0);
        chk("abort_exec_aluop", w_alu, 0);
        chk("abort_exec_retired", w_ret, 0);
        chk("abort_exec_rf_we2", w_rf, 0);

        // rst during WB: no write strobe and no retire
        start();
        r_op = 6'd0; r_funct = 6'b101011; r_ready = 1'b1;
        nxt(); nxt(); nxt(); nxt(); nxt();
        r_rst_b = 1'b1;
        #1;
        chk("abort_wb_rf_we", w_rf, 0);
        chk("abort_wb_pc_we", w_pc, 0);
        nxt();
        r_rst_b = 1'b0; r_run = 1'b0;
        #1;
        chk("abort_wb_retired", w_ret, 0);
        chk("abort_wb_busy", w_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
